// File: rtl/timer_ctrl.sv
// timer_ctrl: debounced start/clear keys, IDLE/RUN/PAUSE/DONE run control, 1 s tick, clear pulse, alarm blink.
// Build option: define TIMER_CTRL_PAUSE_EN to enable the PAUSE state (start toggles RUN/PAUSE).
module timer_ctrl #(
   parameter int CLK_HZ       = 10000,
   parameter int DEBOUNCE_CYC = 200,
   parameter int LIMIT_SEC    = 180,
   parameter int BLINK_CYC    = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start_n,
   input  logic       key_clear_n,
   output logic       sec_tick,
   output logic       clear,
   output logic [7:0] elapsed_sec,
   output logic [1:0] state,
   output logic       alarm_led
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DEB_TC   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYC - 1);
   localparam logic [7:0]    LAST_SEC = 8'(LIMIT_SEC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // key index 0 = start, 1 = clear
   logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]         deb_q, deb_d, deb_dly_q, deb_dly_d;
   logic [1:0][DW-1:0] dcnt_q, dcnt_d;
   logic [1:0]         press;
   logic               start_p, clear_p, wrap;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    elapsed_q, elapsed_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          tick_q, tick_d, clear_q, clear_d, alarm_q, alarm_d;

   always_comb begin
      sync1_d   = {key_clear_n, key_start_n};
      sync2_d   = sync1_q;
      deb_dly_d = deb_q;
      deb_d     = deb_q;
      dcnt_d    = dcnt_q;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] == deb_q[k]) begin
            dcnt_d[k] = '0;
         end else if (dcnt_q[k] == DEB_TC) begin
            deb_d[k]  = sync2_q[k];
            dcnt_d[k] = '0;
         end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
         end
      end
   end

   // falling edge of the debounced level only; releases give nothing
   assign press   = deb_dly_q & ~deb_q;
   assign start_p = press[0];
   assign clear_p = press[1];
   assign wrap    = (state_q == S_RUN) && (presc_q == PRESC_TC);

   always_comb begin
      state_d   = state_q;
      elapsed_d = elapsed_q;
      tick_d    = 1'b0;
      clear_d   = 1'b0;
      alarm_d   = 1'b0;
      blink_d   = '0;
      case (state_q)
         S_RUN:   presc_d = wrap ? '0 : presc_q + 1'b1;
         S_PAUSE: presc_d = presc_q;
         default: presc_d = '0;
      endcase
      if (wrap) begin
         tick_d    = 1'b1;
         elapsed_d = elapsed_q + 1'b1;
      end

      if (clear_p) begin
         state_d   = S_IDLE;
         presc_d   = '0;
         elapsed_d = '0;
         tick_d    = 1'b0;
         clear_d   = 1'b1;
      end else if (wrap && elapsed_q == LAST_SEC) begin
         state_d = S_DONE;
      end else if (start_p) begin
         case (state_q)
            S_IDLE: state_d = S_RUN;
`ifdef TIMER_CTRL_PAUSE_EN
            S_RUN:   state_d = S_PAUSE;
            S_PAUSE: state_d = S_RUN;
`endif
            S_DONE: begin
               state_d   = S_IDLE;
               elapsed_d = '0;
               clear_d   = 1'b1;
            end
            default: state_d = state_q;
         endcase
      end

      // LED lit on the DONE entry cycle, then toggles every BLINK_CYC cycles
      if (state_d == S_DONE) begin
         if (state_q != S_DONE) begin
            alarm_d = 1'b1;
         end else if (blink_q == BLINK_TC) begin
            alarm_d = ~alarm_q;
         end else begin
            alarm_d = alarm_q;
            blink_d = blink_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         deb_q     <= '1;
         deb_dly_q <= '1;
         dcnt_q    <= '0;
         state_q   <= S_IDLE;
         presc_q   <= '0;
         elapsed_q <= '0;
         blink_q   <= '0;
         tick_q    <= 1'b0;
         clear_q   <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         dcnt_q    <= dcnt_d;
         state_q   <= state_d;
         presc_q   <= presc_d;
         elapsed_q <= elapsed_d;
         blink_q   <= blink_d;
         tick_q    <= tick_d;
         clear_q   <= clear_d;
         alarm_q   <= alarm_d;
      end
   end

   assign sec_tick    = tick_q;
   assign clear       = clear_q;
   assign elapsed_sec = elapsed_q;
   assign state       = state_q;
   assign alarm_led   = alarm_q;

endmodule
